// File: rtl/arrow_board_ctrl.sv
// Arrow board sequencer: runs a prescaled lamp phase and plays a 4-entry pattern playlist.
// A manual override can take over the outputs. Every mode change lands on a phase-cycle boundary.
module arrow_board_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] prescale,
    input  logic       run,
    input  logic       prog_we,
    input  logic [1:0] prog_addr,
    input  logic [9:0] prog_data,
    input  logic       ovr_req,
    input  logic [5:0] ovr_pattern,
    output logic       ovr_ack,
    output logic [1:0] phase,
    output logic [3:0] pattern,
    output logic       flashing,
    output logic       sequential,
    output logic [1:0] step,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_OVERRIDE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] presc_cnt_reg;
    logic [1:0] phase_reg;
    logic [9:0] playlist_reg [4];
    logic [3:0] act_pattern_reg, act_pattern_next;
    logic       act_flash_reg, act_flash_next;
    logic       act_seq_reg, act_seq_next;
    logic [3:0] dwell_cnt_reg, dwell_cnt_next;
    logic [1:0] step_reg, step_next;
    logic [5:0] ovr_pat_reg;

    logic       tick;
    logic       wrap;
    logic [3:0] entry_live;
    logic [1:0] next_idx;
    logic       load_en;
    logic [1:0] load_idx;
    logic [9:0] load_entry;

    assign tick     = (presc_cnt_reg == 8'd0);
    assign wrap     = tick && (phase_reg == 2'd3);
    assign next_idx = step_reg + 2'd1;

    // A zero dwell field marks an entry as the end of the playlist.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_entry
            assign entry_live[gi] = |playlist_reg[gi][9:6];
        end
    endgenerate

    assign load_entry = playlist_reg[load_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_reg <= 8'd0;
            phase_reg     <= 2'd0;
        end else begin
            presc_cnt_reg <= tick ? prescale : (presc_cnt_reg - 8'd1);
            if (tick) begin
                phase_reg <= phase_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                playlist_reg[i] <= 10'd0;
            end
        end else if (prog_we) begin
            playlist_reg[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            act_pattern_reg <= 4'd0;
            act_flash_reg   <= 1'b0;
            act_seq_reg     <= 1'b0;
            dwell_cnt_reg   <= 4'd0;
            step_reg        <= 2'd0;
            ovr_pat_reg     <= 6'd0;
        end else begin
            state_reg       <= state_next;
            act_pattern_reg <= act_pattern_next;
            act_flash_reg   <= act_flash_next;
            act_seq_reg     <= act_seq_next;
            dwell_cnt_reg   <= dwell_cnt_next;
            step_reg        <= step_next;
            ovr_pat_reg     <= ovr_pattern;
        end
    end

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        load_en    = 1'b0;
        load_idx   = step_reg;
        dwell_cnt_next = dwell_cnt_reg;
        if (wrap) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (ovr_req) begin
                        state_next = ST_OVERRIDE;
                        step_next  = 2'd0;
                    end else if (run && entry_live[0]) begin
                        state_next = ST_PLAY;
                        load_en    = 1'b1;
                        load_idx   = 2'd0;
                        step_next  = 2'd0;
                    end
                end
                ST_PLAY: begin
                    if (ovr_req) begin
                        state_next = ST_OVERRIDE;
                    end else if (!run) begin
                        state_next = ST_IDLE;
                        step_next  = 2'd0;
                    end else if (dwell_cnt_reg > 4'd1) begin
                        dwell_cnt_next = dwell_cnt_reg - 4'd1;
                    end else if ((step_reg != 2'd3) && entry_live[next_idx]) begin
                        load_en   = 1'b1;
                        load_idx  = next_idx;
                        step_next = next_idx;
                    end else if (entry_live[0]) begin
                        load_en   = 1'b1;
                        load_idx  = 2'd0;
                        step_next = 2'd0;
                    end else begin
                        state_next = ST_IDLE;
                        step_next  = 2'd0;
                    end
                end
                ST_OVERRIDE: begin
                    // Resume restarts the interrupted entry with its full dwell.
                    if (!ovr_req) begin
                        if (run && entry_live[step_reg]) begin
                            state_next = ST_PLAY;
                            load_en    = 1'b1;
                            load_idx   = step_reg;
                        end else begin
                            state_next = ST_IDLE;
                            step_next  = 2'd0;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    step_next  = 2'd0;
                end
            endcase
        end
        act_pattern_next = load_en ? load_entry[3:0] : act_pattern_reg;
        act_flash_next   = load_en ? load_entry[4]   : act_flash_reg;
        act_seq_next     = load_en ? load_entry[5]   : act_seq_reg;
        if (load_en) begin
            dwell_cnt_next = load_entry[9:6];
        end
    end

    always_comb begin
        pattern    = 4'd0;
        flashing   = 1'b0;
        sequential = 1'b0;
        ovr_ack    = 1'b0;
        busy       = 1'b0;
        step       = 2'd0;
        phase      = phase_reg;
        unique case (state_reg)
            ST_PLAY: begin
                pattern    = act_pattern_reg;
                flashing   = act_flash_reg;
                sequential = act_seq_reg;
                busy       = 1'b1;
                step       = step_reg;
            end
            ST_OVERRIDE: begin
                pattern    = ovr_pat_reg[3:0];
                flashing   = ovr_pat_reg[4];
                sequential = ovr_pat_reg[5];
                ovr_ack    = 1'b1;
                busy       = 1'b1;
                step       = step_reg;
            end
            default: begin
                pattern = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_arrow_board_ctrl.sv
// Directed bench for arrow_board_ctrl: prescaler, playlist playback, override, run drop and reset.
module tb_arrow_board_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] prescale;
    logic       run;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [9:0] prog_data;
    logic       ovr_req;
    logic [5:0] ovr_pattern;
    logic       ovr_ack;
    logic [1:0] phase;
    logic [3:0] pattern;
    logic       flashing;
    logic       sequential;
    logic [1:0] step;
    logic       busy;

    int checks = 0;
    int errors = 0;

    arrow_board_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .prescale   (prescale),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .ovr_req    (ovr_req),
        .ovr_pattern(ovr_pattern),
        .ovr_ack    (ovr_ack),
        .phase      (phase),
        .pattern    (pattern),
        .flashing   (flashing),
        .sequential (sequential),
        .step       (step),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        ovr_req = 1'b0;
        prog_we = 1'b0;
        tick_clk(2);
        rst = 1'b0;
    endtask

    task automatic prog(input logic [1:0] a, input logic [9:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick_clk(1);
        prog_we = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 16) begin
            tick_clk(1);
            n++;
        end
        checks++;
        if (busy !== 1'b1 || phase !== 2'd0) begin
            errors++;
            $display("FAIL %s_start: busy=%b phase=%0d required busy=1 phase=0", name, busy, phase);
        end
        $display("txn %s_start busy=%b phase=%0d", name, busy, phase);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prescale = 8'd5;
        run = 1'b1;
        ovr_req = 1'b0;
        ovr_pattern = 6'h3f;
        prog_we = 1'b0;
        prog_addr = 2'd0;
        prog_data = 10'd0;
        tick_clk(3);
        checks++;
        if (phase !== 2'd0 || pattern !== 4'd0 || flashing !== 1'b0 || sequential !== 1'b0 ||
            step !== 2'd0 || busy !== 1'b0 || ovr_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset: phase=%0d pattern=%0d flash=%b seq=%b step=%0d busy=%b ack=%b required all 0",
                     phase, pattern, flashing, sequential, step, busy, ovr_ack);
        end
        $display("txn reset phase=%0d busy=%b", phase, busy);
    endtask

    task automatic test_prescale();
        int exp_phase;
        prescale = 8'd3;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            tick_clk(1);
            exp_phase = ((k - 1) / 4 + 1) % 4;
            checks++;
            if (phase !== exp_phase[1:0] || pattern !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL prescale_clk%0d: phase=%0d pattern=%0d busy=%b required phase=%0d pattern=0 busy=0",
                         k, phase, pattern, busy, exp_phase);
            end
            $display("txn prescale clk=%0d phase=%0d", k, phase);
        end
    endtask

    task automatic test_play();
        logic [3:0] exp_pat;
        logic       exp_flash;
        logic [1:0] exp_step;
        prescale = 8'd0;
        do_reset();
        prog(2'd0, {4'd2, 1'b0, 1'b0, 4'd5});
        prog(2'd1, {4'd1, 1'b0, 1'b1, 4'd9});
        prog(2'd2, 10'd0);
        run = 1'b1;
        wait_busy("play");
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                exp_pat = 4'd5; exp_flash = 1'b0; exp_step = 2'd0;
            end else if (i < 12) begin
                exp_pat = 4'd9; exp_flash = 1'b1; exp_step = 2'd1;
            end else begin
                exp_pat = 4'd5; exp_flash = 1'b0; exp_step = 2'd0;
            end
            checks++;
            if (pattern !== exp_pat || flashing !== exp_flash || step !== exp_step || phase !== 2'(i % 4)) begin
                errors++;
                $display("FAIL play_clk%0d: pattern=%0d flash=%b step=%0d phase=%0d required %0d %b %0d %0d",
                         i, pattern, flashing, step, phase, exp_pat, exp_flash, exp_step, i % 4);
            end
            $display("txn play clk=%0d pattern=%0d flash=%b step=%0d", i, pattern, flashing, step);
            tick_clk(1);
        end
    endtask

    task automatic test_override();
        int n = 0;
        while (step !== 2'd1 && n < 16) begin
            tick_clk(1);
            n++;
        end
        checks++;
        if (step !== 2'd1 || phase !== 2'd0) begin
            errors++;
            $display("FAIL ovr_wait_step1: step=%0d phase=%0d required step=1 phase=0", step, phase);
        end
        ovr_req = 1'b1;
        ovr_pattern = 6'b10_0011;
        tick_clk(3);
        checks++;
        if (ovr_ack !== 1'b0 || pattern !== 4'd9) begin
            errors++;
            $display("FAIL ovr_before_wrap: ack=%b pattern=%0d required ack=0 pattern=9", ovr_ack, pattern);
        end
        tick_clk(1);
        checks++;
        if (ovr_ack !== 1'b1 || pattern !== 4'd3 || sequential !== 1'b1 || flashing !== 1'b0 ||
            busy !== 1'b1 || step !== 2'd1) begin
            errors++;
            $display("FAIL ovr_enter: ack=%b pattern=%0d seq=%b flash=%b busy=%b step=%0d required 1 3 1 0 1 1",
                     ovr_ack, pattern, sequential, flashing, busy, step);
        end
        $display("txn ovr_enter ack=%b pattern=%0d", ovr_ack, pattern);
        ovr_pattern = 6'b01_0111;
        tick_clk(1);
        checks++;
        if (pattern !== 4'd7 || flashing !== 1'b1 || sequential !== 1'b0) begin
            errors++;
            $display("FAIL ovr_track: pattern=%0d flash=%b seq=%b required 7 1 0", pattern, flashing, sequential);
        end
        ovr_req = 1'b0;
        tick_clk(2);
        checks++;
        if (ovr_ack !== 1'b1) begin
            errors++;
            $display("FAIL ovr_hold_to_wrap: ack=%b required 1", ovr_ack);
        end
        tick_clk(1);
        checks++;
        if (ovr_ack !== 1'b0 || pattern !== 4'd9 || flashing !== 1'b1 || step !== 2'd1 || phase !== 2'd0) begin
            errors++;
            $display("FAIL ovr_resume: ack=%b pattern=%0d flash=%b step=%0d phase=%0d required 0 9 1 1 0",
                     ovr_ack, pattern, flashing, step, phase);
        end
        $display("txn ovr_resume step=%0d pattern=%0d", step, pattern);
        tick_clk(3);
        checks++;
        if (step !== 2'd1 || pattern !== 4'd9) begin
            errors++;
            $display("FAIL ovr_full_dwell: step=%0d pattern=%0d required step=1 pattern=9", step, pattern);
        end
        tick_clk(1);
        checks++;
        if (step !== 2'd0 || pattern !== 4'd5) begin
            errors++;
            $display("FAIL ovr_after_dwell: step=%0d pattern=%0d required step=0 pattern=5", step, pattern);
        end
        $display("txn ovr_after_dwell step=%0d pattern=%0d", step, pattern);
    endtask

    task automatic test_all_dwell1();
        int es;
        prescale = 8'd0;
        do_reset();
        for (int e = 0; e < 4; e++) begin
            prog(2'(e), {4'd1, 2'b00, 4'(e + 1)});
        end
        run = 1'b1;
        wait_busy("dwell1");
        for (int i = 0; i < 20; i++) begin
            es = (i / 4) % 4;
            checks++;
            if (step !== 2'(es) || pattern !== 4'(es + 1)) begin
                errors++;
                $display("FAIL dwell1_clk%0d: step=%0d pattern=%0d required step=%0d pattern=%0d",
                         i, step, pattern, es, es + 1);
            end
            $display("txn dwell1 clk=%0d step=%0d pattern=%0d", i, step, pattern);
            tick_clk(1);
        end
    endtask

    task automatic test_run_drop();
        tick_clk(1);
        run = 1'b0;
        tick_clk(2);
        checks++;
        if (busy !== 1'b1 || step !== 2'd1 || pattern !== 4'd2) begin
            errors++;
            $display("FAIL run_drop_hold: busy=%b step=%0d pattern=%0d required 1 1 2", busy, step, pattern);
        end
        tick_clk(1);
        checks++;
        if (busy !== 1'b0 || pattern !== 4'd0 || step !== 2'd0 || flashing !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_idle: busy=%b pattern=%0d step=%0d flash=%b required 0 0 0 0",
                     busy, pattern, step, flashing);
        end
        $display("txn run_drop busy=%b", busy);
        prog(2'd0, 10'd0);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick_clk(1);
            checks++;
            if (busy !== 1'b0 || pattern !== 4'd0) begin
                errors++;
                $display("FAIL empty_list_clk%0d: busy=%b pattern=%0d required busy=0 pattern=0", i, busy, pattern);
            end
            $display("txn empty_list clk=%0d busy=%b", i, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_override();
        int n = 0;
        ovr_pattern = 6'h3f;
        ovr_req = 1'b1;
        while (ovr_ack !== 1'b1 && n < 8) begin
            tick_clk(1);
            n++;
        end
        checks++;
        if (ovr_ack !== 1'b1 || pattern !== 4'hf || flashing !== 1'b1 || sequential !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_ovr_enter: ack=%b pattern=%0d flash=%b seq=%b busy=%b required 1 15 1 1 1",
                     ovr_ack, pattern, flashing, sequential, busy);
        end
        tick_clk(1);
        rst = 1'b1;
        tick_clk(1);
        checks++;
        if (ovr_ack !== 1'b0 || phase !== 2'd0 || pattern !== 4'd0 || flashing !== 1'b0 ||
            sequential !== 1'b0 || busy !== 1'b0 || step !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_ovr: ack=%b phase=%0d pattern=%0d flash=%b seq=%b busy=%b step=%0d required all 0",
                     ovr_ack, phase, pattern, flashing, sequential, busy, step);
        end
        $display("txn rst_mid_ovr ack=%b phase=%0d", ovr_ack, phase);
        ovr_req = 1'b0;
        rst = 1'b0;
        tick_clk(1);
        checks++;
        if (phase !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL first_tick_after_rst: phase=%0d busy=%b required phase=1 busy=0", phase, busy);
        end
        $display("txn first_tick phase=%0d", phase);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_prescale();
        test_play();
        test_override();
        test_all_dwell1();
        test_run_drop();
        test_reset_mid_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
